avr_stage_sequencer: RTL and testbench

Multi-cycle control FSM for the AVR-based RISC core. Generates the one-hot stage enables en_Fetch, en_Decode, en_Execute and en_Writeback, and owns the program counter and instruction register. Sits between program memory and the decode/ALU/register-file datapath. Sequences one instruction at a time with fetch wait-states, branch redirect, optional writeback skip, and halt.

---
 rtl/avr_stage_sequencer_if.sv | 40 ++++
 rtl/avr_stage_sequencer.sv | 99 +++++++++
 tb/tb_avr_stage_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_stage_sequencer_if.sv
// Bundle of run control, program-memory, ALU/decoder and stage-enable signals around avr_stage_sequencer.
// With SEQ_PERF_EN defined the bundle also carries instr_count and stall_count.
interface avr_stage_sequencer_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic            mem_ready;
    logic [15:0]     instruction;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            wb_needed;
    logic            en_Fetch;
    logic            en_Decode;
    logic            en_Execute;
    logic            en_Writeback;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic            halted;
    logic [2:0]      state;
`ifdef SEQ_PERF_EN
    logic [15:0]     instr_count;
    logic [15:0]     stall_count;
`endif

    modport master (
        input  run, mem_ready, instruction, branch_taken, branch_target, wb_needed,
        output en_Fetch, en_Decode, en_Execute, en_Writeback, pc, ir, halted, state
`ifdef SEQ_PERF_EN
        , output instr_count, stall_count
`endif
    );

    modport slave (
        output run, mem_ready, instruction, branch_taken, branch_target, wb_needed,
        input  en_Fetch, en_Decode, en_Execute, en_Writeback, pc, ir, halted, state
`ifdef SEQ_PERF_EN
        , input instr_count, stall_count
`endif
    );
endinterface

// File: rtl/avr_stage_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning pc and ir for the AVR-style core.
// Optional SEQ_PERF_EN adds saturating instr_count and stall_count counters.
module avr_stage_sequencer #(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [15:0]     HALT_OPCODE = 16'h9598
) (
    input logic clk,
    input logic rst,
    avr_stage_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    logic [2:0]      state_q;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;
    logic            halted_q;

    // Memory handshake: FETCH holds en_Fetch as the request; the word is taken
    // on any edge where mem_ready=1 in FETCH, with no limit on wait cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.run) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_q    <= bus.instruction;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (ir_q == HALT_OPCODE) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    pc_q <= bus.branch_taken ? bus.branch_target : pc_q + PC_W'(1);
                    if (bus.wb_needed)  state_q <= S_WRITEBACK;
                    else if (bus.run)   state_q <= S_FETCH;
                    else                state_q <= S_IDLE;
                end
                S_WRITEBACK: begin
                    state_q <= bus.run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.en_Fetch     = (state_q == S_FETCH);
    assign bus.en_Decode    = (state_q == S_DECODE);
    assign bus.en_Execute   = (state_q == S_EXECUTE);
    assign bus.en_Writeback = (state_q == S_WRITEBACK);
    assign bus.pc           = pc_q;
    assign bus.ir           = ir_q;
    assign bus.halted       = halted_q;
    assign bus.state        = state_q;

`ifdef SEQ_PERF_EN
    logic [15:0] instr_cnt_q;
    logic [15:0] stall_cnt_q;

    // Halt instructions leave DECODE towards HALT and so never bump instr_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            if (state_q == S_DECODE && ir_q != HALT_OPCODE && instr_cnt_q != 16'hFFFF)
                instr_cnt_q <= instr_cnt_q + 16'd1;
            if (state_q == S_FETCH && !bus.mem_ready && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.instr_count = instr_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_avr_stage_sequencer.sv
// Self-checking bench for avr_stage_sequencer: each instruction is described by its
// parameters and the expected per-cycle stage list, pc and ir follow from those rules.
module tb_avr_stage_sequencer;
    localparam logic [2:0]  ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2;
    localparam logic [2:0]  ST_EXECUTE = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;
    localparam logic [15:0] HALT_OP = 16'h9598;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    avr_stage_sequencer_if #(.PC_W(8)) bus();
    avr_stage_sequencer #(.PC_W(8), .RESET_PC(8'h00), .HALT_OPCODE(16'h9598)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [7:0] pc_model;
    int instr_model;
    int stall_model;

    function automatic logic [3:0] exp_en(input logic [2:0] s);
        case (s)
            ST_FETCH:   return 4'b0001;
            ST_DECODE:  return 4'b0010;
            ST_EXECUTE: return 4'b0100;
            ST_WB:      return 4'b1000;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] en_vec();
        return {bus.en_Writeback, bus.en_Execute, bus.en_Decode, bus.en_Fetch};
    endfunction

    // Caller sits at a negedge with inputs set so the DUT enters FETCH on the next edge.
    task automatic run_instr(input logic [15:0] instr, input int waits, input logic br,
                             input logic [7:0] tgt, input logic wb, input logic keep_run);
        logic [2:0] exp_q[$];
        logic [2:0] stg;
        int f_idx = 0;
        for (int i = 0; i <= waits; i++) exp_q.push_back(ST_FETCH);
        exp_q.push_back(ST_DECODE);
        if (instr != HALT_OP) begin
            exp_q.push_back(ST_EXECUTE);
            if (wb) exp_q.push_back(ST_WB);
        end
        while (exp_q.size() > 0) begin
            stg = exp_q.pop_front();
            @(negedge clk);
            chk_cnt++;
            if (bus.state !== stg) $display("FAIL stage_state: got %0d want %0d", bus.state, stg);
            else pass_cnt++;
            chk_cnt++;
            if (en_vec() !== exp_en(stg)) $display("FAIL stage_enables: got %b want %b", en_vec(), exp_en(stg));
            else pass_cnt++;
            chk_cnt++;
            if (bus.pc !== pc_model) $display("FAIL stage_pc: got %h want %h", bus.pc, pc_model);
            else pass_cnt++;
            chk_cnt++;
            if (bus.halted !== 1'b0) $display("FAIL stage_halted: got %b want 0", bus.halted);
            else pass_cnt++;
            if (stg == ST_DECODE) begin
                chk_cnt++;
                if (bus.ir !== instr) $display("FAIL ir_latch: got %h want %h", bus.ir, instr);
                else pass_cnt++;
            end
            bus.mem_ready   = (stg == ST_FETCH) ? (f_idx == waits) : 1'($urandom_range(0, 1));
            bus.instruction = (stg == ST_FETCH) ? instr : 16'($urandom);
            if (stg == ST_FETCH) begin
                if (f_idx != waits) stall_model++;
                f_idx++;
            end
            if (stg == ST_EXECUTE) begin
                bus.branch_taken  = br;
                bus.branch_target = tgt;
                bus.wb_needed     = wb;
                pc_model = br ? tgt : pc_model + 8'd1;
            end else begin
                bus.branch_taken  = 1'($urandom_range(0, 1));
                bus.branch_target = 8'($urandom);
                bus.wb_needed     = 1'($urandom_range(0, 1));
            end
            if (stg == ST_DECODE) begin
                if (instr != HALT_OP) instr_model++;
                if (!keep_run) bus.run = 1'b0;
            end
        end
        if (!keep_run && instr != HALT_OP) begin
            @(negedge clk);
            chk_cnt++;
            if (bus.state !== ST_IDLE || en_vec() !== 4'b0000)
                $display("FAIL run_drop_idle: got state %0d en %b want 0/0000", bus.state, en_vec());
            else pass_cnt++;
            chk_cnt++;
            if (bus.pc !== pc_model) $display("FAIL run_drop_pc: got %h want %h", bus.pc, pc_model);
            else pass_cnt++;
            bus.run = 1'b1;
        end
    endtask

    task automatic reset_models();
        pc_model    = 8'h00;
        instr_model = 0;
        stall_model = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk_cnt++;
        if (bus.state !== ST_IDLE) $display("FAIL %s_state: got %0d want 0", tag, bus.state);
        else pass_cnt++;
        chk_cnt++;
        if (en_vec() !== 4'b0000) $display("FAIL %s_enables: got %b want 0000", tag, en_vec());
        else pass_cnt++;
        chk_cnt++;
        if (bus.pc !== 8'h00 || bus.ir !== 16'h0000 || bus.halted !== 1'b0)
            $display("FAIL %s_regs: got pc %h ir %h halted %b want 00 0000 0", tag, bus.pc, bus.ir, bus.halted);
        else pass_cnt++;
    endtask

    task automatic test_perf_counters();
`ifdef SEQ_PERF_EN
        chk_cnt++;
        if (bus.instr_count !== 16'(instr_model))
            $display("FAIL instr_count: got %0d want %0d", bus.instr_count, instr_model);
        else pass_cnt++;
        chk_cnt++;
        if (bus.stall_count !== 16'(stall_model))
            $display("FAIL stall_count: got %0d want %0d", bus.stall_count, stall_model);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.run = 1'b0; bus.mem_ready = 1'b0; bus.instruction = 16'h0000;
        bus.branch_taken = 1'b0; bus.branch_target = 8'h00; bus.wb_needed = 1'b0;
        reset_models();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("idle_hold");
        test_perf_counters();
    endtask

    task automatic test_basic();
        bus.run = 1'b1;
        run_instr(16'h0C01, 0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_wait_states();
        run_instr(16'h1234, 3, 1'b0, 8'h00, 1'b1, 1'b1);
        test_perf_counters();
    endtask

    task automatic test_branch_skip_wb();
        run_instr(16'hC005, 0, 1'b1, 8'h40, 1'b0, 1'b1);
    endtask

    task automatic test_pc_wrap();
        run_instr(16'hC0FF, 1, 1'b1, 8'hFF, 1'b0, 1'b1);
        run_instr(16'h0E22, 0, 1'b0, 8'h13, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [15:0] op;
        for (int n = 0; n < 25; n++) begin
            do op = 16'($urandom); while (op == HALT_OP);
            run_instr(op, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        test_perf_counters();
    endtask

    task automatic test_back_to_back_run_drop();
        run_instr(16'h2C45, 0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_instr(16'h2C46, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (bus.state !== ST_FETCH || en_vec() !== 4'b0001)
                $display("FAIL fetch_wait: got state %0d en %b want 1/0001", bus.state, en_vec());
            else pass_cnt++;
            bus.mem_ready = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("reset_mid_fetch");
        reset_models();
        test_perf_counters();
        rst = 1'b0;
    endtask

    task automatic test_halt();
        logic [7:0] pc_at_halt;
        run_instr(16'h0F0F, 0, 1'b0, 8'h00, 1'b0, 1'b1);
        pc_at_halt = pc_model;
        run_instr(HALT_OP, 1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (bus.state !== ST_HALT || en_vec() !== 4'b0000 || bus.halted !== 1'b1)
                $display("FAIL halt_hold: got state %0d en %b halted %b want 5/0000/1", bus.state, en_vec(), bus.halted);
            else pass_cnt++;
            chk_cnt++;
            if (bus.pc !== pc_at_halt || bus.ir !== HALT_OP)
                $display("FAIL halt_frozen: got pc %h ir %h want %h %h", bus.pc, bus.ir, pc_at_halt, HALT_OP);
            else pass_cnt++;
            bus.run = 1'b1;
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.instruction = 16'($urandom);
            bus.branch_taken = 1'($urandom_range(0, 1));
            bus.branch_target = 8'($urandom);
            bus.wb_needed = 1'($urandom_range(0, 1));
        end
        test_perf_counters();
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("halt_reset");
        reset_models();
        rst = 1'b0;
        bus.run = 1'b0;
        @(negedge clk);
        check_reset_values("post_halt_idle");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_branch_skip_wb();
        test_pc_wrap();
        test_random();
        test_back_to_back_run_drop();
        test_reset_mid_fetch();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
